trace_pkt_serializer: RTL and testbench

Parametrised trace buffer between the decode/retire trace port and the off-core trace sink. Captures a multi-lane retirement trace packet per cycle (any lane count), queues it in a DEPTH-entry FIFO, and replays it as a one-instruction-per-cycle stream with valid/ready handshake. Retirement cannot stall, so overflow drops whole packets and counts them. Next generation of the fixed 3-lane trace packet: lane count, queue depth and exception attribution are now parameters and behaviour.

---
 rtl/trace_pkt_serializer_pkg.sv | 19 +
 rtl/trace_lane_pick.sv | 25 ++
 rtl/trace_pkt_serializer.sv | 157 +++++++++++++++
 tb/tb_trace_pkt_serializer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkt_serializer_pkg.sv
// Shared trace types: per-lane retirement record and field widths.
package trace_pkt_serializer_pkg;
   localparam int TRACE_INSN_W   = 32;
   localparam int TRACE_ADDR_W   = 32;
   localparam int TRACE_ECAUSE_W = 5;
   localparam int TRACE_TVAL_W   = 32;

   typedef struct packed {
      logic [TRACE_INSN_W-1:0] insn;
      logic [TRACE_ADDR_W-1:0] addr;
      logic                    exception;
      logic                    interrupt;
   } trace_entry_t;

   // Index width for a lane/entry count, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/trace_lane_pick.sv
// Lowest-set-bit picker over a lane mask; combinational, zero latency, no flow control.
module trace_lane_pick
   import trace_pkt_serializer_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  mask,
   output logic [IW-1:0] idx,
   output logic [N-1:0]  onehot,
   output logic          any,
   output logic          last
);

   always_comb begin
      onehot = mask & (~mask + N'(1));
      any    = |mask;
      last   = any && ((mask & (mask - N'(1))) == '0);
      idx    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/trace_pkt_serializer.sv
// Queues multi-lane retire packets and replays one lane per beat; first beat one cycle after push.
// Sink stalls via out_ready hold the head; retirement never stalls, so a full queue drops whole packets.
module trace_pkt_serializer
   import trace_pkt_serializer_pkg::*;
#(
   parameter int LANES = 3,
   parameter int DEPTH = 4,
   parameter int DROPW = 16,
   parameter int LW    = idx_w(LANES)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [LANES-1:0]              in_valid,
   input  logic [TRACE_INSN_W*LANES-1:0] in_insn,
   input  logic [TRACE_ADDR_W*LANES-1:0] in_addr,
   input  logic [LANES-1:0]              in_exception,
   input  logic [LANES-1:0]              in_interrupt,
   input  logic [TRACE_ECAUSE_W-1:0]     in_ecause,
   input  logic [TRACE_TVAL_W-1:0]       in_tval,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [TRACE_INSN_W-1:0]       out_insn,
   output logic [TRACE_ADDR_W-1:0]       out_addr,
   output logic                          out_exception,
   output logic                          out_interrupt,
   output logic [TRACE_ECAUSE_W-1:0]     out_ecause,
   output logic [TRACE_TVAL_W-1:0]       out_tval,
   output logic [LW-1:0]                 out_lane,
   output logic                          out_last,
   output logic                          ovf_sticky,
   input  logic                          ovf_clear,
   output logic [DROPW-1:0]              drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   trace_entry_t              lane_q   [DEPTH][LANES];
   trace_entry_t              lane_d   [DEPTH][LANES];
   logic [TRACE_ECAUSE_W-1:0] ecause_q [DEPTH];
   logic [TRACE_ECAUSE_W-1:0] ecause_d [DEPTH];
   logic [TRACE_TVAL_W-1:0]   tval_q   [DEPTH];
   logic [TRACE_TVAL_W-1:0]   tval_d   [DEPTH];
   logic [LANES-1:0]          mask_q   [DEPTH];
   logic [LANES-1:0]          mask_d   [DEPTH];
   logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DROPW-1:0]          drop_cnt_q, drop_cnt_d;
   logic                      ovf_q, ovf_d;

   logic [AW-1:0]    wr_idx, rd_idx;
   logic             empty, full, push_req, push, drop, accept, pop;
   logic [LANES-1:0] head_mask, head_onehot;
   logic [LW-1:0]    head_idx;
   logic             head_any, head_last, head_trap;
   trace_entry_t     head_sel;

   assign wr_idx    = wr_ptr_q[AW-1:0];
   assign rd_idx    = rd_ptr_q[AW-1:0];
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
   assign head_mask = mask_q[rd_idx];

   trace_lane_pick #(.N(LANES), .IW(LW)) u_pick (
      .mask   (head_mask),
      .idx    (head_idx),
      .onehot (head_onehot),
      .any    (head_any),
      .last   (head_last)
   );

   always_comb begin
      head_sel = '0;
      for (int l = 0; l < LANES; l++) begin
         if (head_onehot[l]) head_sel = lane_q[rd_idx][l];
      end
      head_trap = head_sel.exception | head_sel.interrupt;
   end

   // Everything is gated by out_valid so an empty queue presents all-zero beats.
   always_comb begin
      out_valid     = ~empty & head_any;
      out_insn      = out_valid ? head_sel.insn : '0;
      out_addr      = out_valid ? head_sel.addr : '0;
      out_exception = out_valid & head_sel.exception;
      out_interrupt = out_valid & head_sel.interrupt;
      out_ecause    = (out_valid && head_trap) ? ecause_q[rd_idx] : '0;
      out_tval      = (out_valid && head_trap) ? tval_q[rd_idx] : '0;
      out_lane      = out_valid ? head_idx : '0;
      out_last      = out_valid & head_last;
      ovf_sticky    = ovf_q;
      drop_cnt      = drop_cnt_q;
   end

   always_comb begin
      accept   = out_valid & out_ready;
      pop      = accept & head_last;
      push_req = |in_valid;
      // A pop of the head frees its slot in time for a same-cycle push.
      push     = push_req & (~full | pop);
      drop     = push_req & full & ~pop;

      lane_d   = lane_q;
      ecause_d = ecause_q;
      tval_d   = tval_q;
      mask_d   = mask_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;

      if (accept) mask_d[rd_idx] = head_mask & ~head_onehot;
      if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) begin
         for (int l = 0; l < LANES; l++) begin
            lane_d[wr_idx][l] = '{insn:      in_insn[TRACE_INSN_W*l +: TRACE_INSN_W],
                                  addr:      in_addr[TRACE_ADDR_W*l +: TRACE_ADDR_W],
                                  exception: in_exception[l],
                                  interrupt: in_interrupt[l]};
         end
         ecause_d[wr_idx] = in_ecause;
         tval_d[wr_idx]   = in_tval;
         mask_d[wr_idx]   = in_valid;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end

      // Clear first so a coinciding drop still registers as the first one.
      drop_cnt_d = ovf_clear ? '0 : drop_cnt_q;
      ovf_d      = ovf_clear ? 1'b0 : ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + DROPW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int l = 0; l < LANES; l++) lane_q[i][l] <= '0;
            ecause_q[i] <= '0;
            tval_q[i]   <= '0;
            mask_q[i]   <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         drop_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         lane_q     <= lane_d;
         ecause_q   <= ecause_d;
         tval_q     <= tval_d;
         mask_q     <= mask_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         drop_cnt_q <= drop_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

endmodule

// File: tb/tb_trace_pkt_serializer.sv
// Bench for trace_pkt_serializer: packet-level reference queue checked every cycle, plus literal spot checks.
module tb_trace_pkt_serializer;
   localparam int L  = 3;
   localparam int D  = 4;
   localparam int DW = 16;
   localparam int LW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [L-1:0]    in_valid, in_exception, in_interrupt;
   logic [32*L-1:0] in_insn, in_addr;
   logic [4:0]      in_ecause;
   logic [31:0]     in_tval;
   logic            out_valid, out_ready, out_exception, out_interrupt, out_last;
   logic [31:0]     out_insn, out_addr, out_tval;
   logic [4:0]      out_ecause;
   logic [LW-1:0]   out_lane;
   logic            ovf_sticky, ovf_clear;
   logic [DW-1:0]   drop_cnt;

   always #5 clk = ~clk;

   trace_pkt_serializer #(.LANES(L), .DEPTH(D), .DROPW(DW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_insn(in_insn), .in_addr(in_addr),
      .in_exception(in_exception), .in_interrupt(in_interrupt),
      .in_ecause(in_ecause), .in_tval(in_tval),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_insn(out_insn), .out_addr(out_addr),
      .out_exception(out_exception), .out_interrupt(out_interrupt),
      .out_ecause(out_ecause), .out_tval(out_tval),
      .out_lane(out_lane), .out_last(out_last),
      .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear), .drop_cnt(drop_cnt)
   );

   typedef struct {
      logic [31:0] insn;
      logic [31:0] addr;
      logic        exc;
      logic        intr;
      logic [4:0]  ec;
      logic [31:0] tv;
      int          lane;
      logic        last;
   } beat_t;

   beat_t         mq[$];
   int            m_pkts;
   logic [DW-1:0] m_drop;
   logic          m_ovf;
   bit            started = 0;
   int            n_vec = 0;
   int            n_fail = 0;

   function automatic logic [31:0] insn_of(input logic [31:0] a);
      return 32'h1300_0000 ^ a;
   endfunction

   // Reference: a queue of pending beats, with packet count for the full test.
   always @(posedge clk) begin
      bit    popped, full_pre;
      beat_t b;
      if (rst) begin
         mq.delete();
         m_pkts = 0;
         m_drop = '0;
         m_ovf  = 1'b0;
      end else begin
         full_pre = (m_pkts == D);
         popped   = 0;
         if (mq.size() > 0 && out_ready) begin
            popped = mq[0].last;
            if (popped) m_pkts--;
            void'(mq.pop_front());
         end
         if (ovf_clear) begin
            m_drop = '0;
            m_ovf  = 1'b0;
         end
         if (in_valid != '0) begin
            if (!full_pre || popped) begin
               for (int l = 0; l < L; l++) begin
                  if (in_valid[l]) begin
                     b.insn = in_insn[32*l +: 32];
                     b.addr = in_addr[32*l +: 32];
                     b.exc  = in_exception[l];
                     b.intr = in_interrupt[l];
                     b.ec   = (b.exc || b.intr) ? in_ecause : 5'd0;
                     b.tv   = (b.exc || b.intr) ? in_tval : 32'd0;
                     b.lane = l;
                     b.last = ((in_valid >> (l + 1)) == '0);
                     mq.push_back(b);
                  end
               end
               m_pkts++;
            end else begin
               m_ovf = 1'b1;
               if (m_drop != '1) m_drop = m_drop + 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [123:0] act, exp;
      if (started) begin
         act = {out_valid, out_insn, out_addr, out_exception, out_interrupt, out_ecause,
                out_tval, out_lane, out_last, ovf_sticky, drop_cnt};
         if (mq.size() > 0)
            exp = {1'b1, mq[0].insn, mq[0].addr, mq[0].exc, mq[0].intr, mq[0].ec,
                   mq[0].tv, LW'(mq[0].lane), mq[0].last, m_ovf, m_drop};
         else
            exp = {1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, {LW{1'b0}}, 1'b0, m_ovf, m_drop};
         n_vec++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL stream t=%0t got %h expected %h", $time, act, exp);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pkt(input logic [L-1:0] v, input logic [L-1:0] exc, input logic [L-1:0] intr,
                          input logic [4:0] ec, input logic [31:0] tv, input logic [31:0] base);
      in_valid     = v;
      in_exception = exc;
      in_interrupt = intr;
      in_ecause    = ec;
      in_tval      = tv;
      for (int l = 0; l < L; l++) begin
         in_addr[32*l +: 32] = base + 32'(4 * l);
         in_insn[32*l +: 32] = insn_of(base + 32'(4 * l));
      end
   endtask

   task automatic idle();
      in_valid     = '0;
      in_exception = '0;
      in_interrupt = '0;
      in_ecause    = '0;
      in_tval      = '0;
      in_insn      = '0;
      in_addr      = '0;
   endtask

   task automatic push1(input logic [L-1:0] v, input logic [31:0] base);
      set_pkt(v, '0, '0, 5'd0, 32'd0, base);
      tick();
      idle();
   endtask

   initial begin
      logic [31:0] held_addr, held_insn;
      rst = 1'b1; out_ready = 1'b1; ovf_clear = 1'b0;
      idle();
      tick();
      started = 1;
      tick();
      rst = 1'b0;
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_drop", 32'(drop_cnt), 32'd0);
      chk("reset_sticky", 32'(ovf_sticky), 32'd0);

      // Sparse packet: lanes 0 and 2.
      push1(3'b101, 32'h100);
      chk("sparse_b0_addr", out_addr, 32'h100);
      chk("sparse_b0_last", 32'(out_last), 32'd0);
      tick();
      chk("sparse_b1_addr", out_addr, 32'h108);
      chk("sparse_b1_lane", 32'(out_lane), 32'd2);
      chk("sparse_b1_last", 32'(out_last), 32'd1);
      tick();
      chk("sparse_done", 32'(out_valid), 32'd0);

      // Trap attribution only on the excepting lane.
      set_pkt(3'b011, 3'b010, 3'b000, 5'd2, 32'hDEAD, 32'h180);
      tick();
      idle();
      chk("trap_b0_ecause", 32'(out_ecause), 32'd0);
      chk("trap_b0_tval", out_tval, 32'd0);
      tick();
      chk("trap_b1_exc", 32'(out_exception), 32'd1);
      chk("trap_b1_ecause", 32'(out_ecause), 32'd2);
      chk("trap_b1_tval", out_tval, 32'hDEAD);
      tick();

      // Backpressure hold.
      out_ready = 1'b0;
      push1(3'b111, 32'h200);
      held_addr = out_addr;
      held_insn = out_insn;
      repeat (5) tick();
      chk("hold_addr", out_addr, held_addr);
      chk("hold_insn", out_insn, held_insn);
      chk("hold_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      repeat (3) tick();
      chk("hold_drained", 32'(out_valid), 32'd0);

      // Overflow: six single-lane packets into four entries.
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) push1(3'b001, 32'h300 + 32'(16 * k));
      chk("ovf_drop", 32'(drop_cnt), 32'd2);
      chk("ovf_sticky", 32'(ovf_sticky), 32'd1);
      push1(3'b000, 32'h3F0);
      chk("ovf_zero_pkt", 32'(drop_cnt), 32'd2);
      ovf_clear = 1'b1;
      tick();
      ovf_clear = 1'b0;
      chk("ovf_clear_cnt", 32'(drop_cnt), 32'd0);
      chk("ovf_clear_sticky", 32'(ovf_sticky), 32'd0);

      // Full queue, head on its last lane, push in the popping cycle.
      out_ready = 1'b1;
      push1(3'b001, 32'h500);
      chk("full_pop_nodrop", 32'(drop_cnt), 32'd0);
      out_ready = 1'b0;
      push1(3'b001, 32'h600);
      chk("still_full", 32'(drop_cnt), 32'd1);
      push1(3'b001, 32'h700);
      set_pkt(3'b001, '0, '0, 5'd0, 32'd0, 32'h800);
      ovf_clear = 1'b1;
      tick();
      ovf_clear = 1'b0;
      idle();
      chk("clear_vs_drop_cnt", 32'(drop_cnt), 32'd1);
      chk("clear_vs_drop_sticky", 32'(ovf_sticky), 32'd1);
      ovf_clear = 1'b1;
      tick();
      ovf_clear = 1'b0;
      out_ready = 1'b1;
      chk("head_after_full", out_addr, 32'h310);
      repeat (3) tick();
      chk("new_after_old", out_addr, 32'h500);
      tick();
      chk("full_drained", 32'(out_valid), 32'd0);

      // Reset with three packets queued.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) push1(3'b111, 32'hC00 + 32'(16 * k));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
      out_ready = 1'b1;
      tick();
      chk("rst_mid_empty", 32'(out_valid), 32'd0);

      // Mixed traps with a stuttering sink.
      set_pkt(3'b111, 3'b001, 3'b100, 5'd7, 32'hBEEF, 32'h900);
      tick();
      set_pkt(3'b110, 3'b000, 3'b010, 5'd9, 32'h1234, 32'hA00);
      out_ready = 1'b0;
      tick();
      idle();
      for (int c = 0; c < 8; c++) begin
         out_ready = (c % 3 != 1);
         tick();
      end
      out_ready = 1'b1;
      repeat (4) tick();
      chk("mixed_drained", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
